// File: rtl/axi_tlb_l1_requester.sv
// Issues L1 translation requests for one AXI Ax channel and keeps beat fields in an
// in-order pending FIFO, then routes each result to the master port (hit) or error port (miss).
module axi_tlb_l1_requester #(
    parameter int InpAddrWidth = 32,
    parameter int OupAddrWidth = 32,
    parameter int PayloadWidth = 64,
    parameter int MaxPending   = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [InpAddrWidth-1:0]           ax_addr_i,
    input  logic [PayloadWidth-1:0]           ax_payload_i,
    input  logic                              ax_valid_i,
    output logic                              ax_ready_o,
    output logic [InpAddrWidth-1:0]           req_addr_o,
    output logic                              req_valid_o,
    input  logic                              req_ready_i,
    input  logic                              res_hit_i,
    input  logic [OupAddrWidth-1:0]           res_addr_i,
    input  logic                              res_valid_i,
    output logic                              res_ready_o,
    output logic [OupAddrWidth-1:0]           mst_addr_o,
    output logic [PayloadWidth-1:0]           mst_payload_o,
    output logic                              mst_valid_o,
    input  logic                              mst_ready_i,
    output logic [InpAddrWidth-1:0]           err_addr_o,
    output logic [PayloadWidth-1:0]           err_payload_o,
    output logic                              err_valid_o,
    input  logic                              err_ready_i,
    output logic [$clog2(MaxPending+1)-1:0]   pending_o
);

    localparam int PtrWidth = (MaxPending > 1) ? $clog2(MaxPending) : 1;
    localparam int CntWidth = $clog2(MaxPending + 1);

    // Pending FIFO storage; the head is read combinationally so it can load the
    // output register in the same cycle the result arrives.
    logic [InpAddrWidth-1:0] addr_mem    [MaxPending];
    logic [PayloadWidth-1:0] payload_mem [MaxPending];

    logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntWidth-1:0] count_reg, count_next;
    logic                full_reg, full_next;
    logic                empty;

    logic                    out_valid_reg, out_valid_next;
    logic                    hit_reg;
    logic [OupAddrWidth-1:0] oup_addr_reg;
    logic [InpAddrWidth-1:0] inp_addr_reg;
    logic [PayloadWidth-1:0] payload_reg;

    logic push;
    logic pop;
    logic out_ready;

    assign empty       = (count_reg == '0);
    assign req_addr_o  = ax_addr_i;
    assign req_valid_o = ax_valid_i && !full_reg;
    assign ax_ready_o  = req_ready_i && !full_reg;
    assign push        = ax_valid_i && req_ready_i && !full_reg;

    assign out_ready   = hit_reg ? mst_ready_i : err_ready_i;
    assign res_ready_o = !empty && (!out_valid_reg || out_ready);
    assign pop         = res_valid_i && res_ready_o;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        out_valid_next = out_valid_reg;

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PtrWidth'(MaxPending - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PtrWidth'(MaxPending - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end

        count_next = count_reg + CntWidth'(push) - CntWidth'(pop);
        full_next  = (count_next == CntWidth'(MaxPending));

        // A new result refills the register in the same cycle it drains.
        if (pop) begin
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_reg]    <= ax_addr_i;
            payload_mem[wr_ptr_reg] <= ax_payload_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            hit_reg       <= 1'b0;
            oup_addr_reg  <= '0;
            inp_addr_reg  <= '0;
            payload_reg   <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            full_reg      <= full_next;
            out_valid_reg <= out_valid_next;
            if (pop) begin
                hit_reg      <= res_hit_i;
                oup_addr_reg <= res_addr_i;
                inp_addr_reg <= addr_mem[rd_ptr_reg];
                payload_reg  <= payload_mem[rd_ptr_reg];
            end
        end
    end

    assign mst_valid_o   = out_valid_reg && hit_reg;
    assign err_valid_o   = out_valid_reg && !hit_reg;
    assign mst_addr_o    = oup_addr_reg;
    assign mst_payload_o = payload_reg;
    assign err_addr_o    = inp_addr_reg;
    assign err_payload_o = payload_reg;
    assign pending_o     = count_reg;

    // L1 must never answer a request that was not issued.
    res_valid_needs_pending: assert property (
        @(posedge clk_i) disable iff (rst_i) res_valid_i |-> !empty
    );

endmodule

// File: tb/tb_axi_tlb_l1_requester.sv
// Directed bench for axi_tlb_l1_requester: reset, hit, miss, full stall,
// ordering under backpressure, streaming throughput and mid-operation reset.
module tb_axi_tlb_l1_requester;

    localparam int IW = 32;
    localparam int OW = 32;
    localparam int PW = 64;
    localparam int MP = 4;
    localparam int CW = $clog2(MP + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [IW-1:0] ax_addr;
    logic [PW-1:0] ax_payload;
    logic          ax_valid, ax_ready;
    logic [IW-1:0] req_addr;
    logic          req_valid, req_ready;
    logic          res_hit;
    logic [OW-1:0] res_addr;
    logic          res_valid, res_ready;
    logic [OW-1:0] mst_addr;
    logic [PW-1:0] mst_payload;
    logic          mst_valid, mst_ready;
    logic [IW-1:0] err_addr;
    logic [PW-1:0] err_payload;
    logic          err_valid, err_ready;
    logic [CW-1:0] pending;

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct {
        logic          hit;
        logic [IW-1:0] addr;
        logic [PW-1:0] pl;
    } exp_t;

    always #5 clk_i = ~clk_i;

    axi_tlb_l1_requester #(
        .InpAddrWidth(IW),
        .OupAddrWidth(OW),
        .PayloadWidth(PW),
        .MaxPending  (MP)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ax_addr_i    (ax_addr),
        .ax_payload_i (ax_payload),
        .ax_valid_i   (ax_valid),
        .ax_ready_o   (ax_ready),
        .req_addr_o   (req_addr),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .res_hit_i    (res_hit),
        .res_addr_i   (res_addr),
        .res_valid_i  (res_valid),
        .res_ready_o  (res_ready),
        .mst_addr_o   (mst_addr),
        .mst_payload_o(mst_payload),
        .mst_valid_o  (mst_valid),
        .mst_ready_i  (mst_ready),
        .err_addr_o   (err_addr),
        .err_payload_o(err_payload),
        .err_valid_o  (err_valid),
        .err_ready_i  (err_ready),
        .pending_o    (pending)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Cycle-level environment: an in-order L1 model answers every issued request,
    // a scoreboard checks each output beat against request order.
    task automatic run_traffic(input int n, input bit all_hit, input bit bp,
                               output int first_cyc, output int last_cyc);
        exp_t          exp_q[$];
        logic [IW-1:0] l1_q[$];
        logic [15:0]   mst_pat;
        logic [15:0]   err_pat;
        int            sent;
        int            got;
        int            cyc;
        bit            mst_stall;
        bit            err_stall;
        bit            up_hs, res_hs, out_hs;
        exp_t          e;
        mst_pat   = 16'b1011_0010_1101_0110;
        err_pat   = 16'b0110_1101_0011_1010;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        mst_stall = 1'b0;
        err_stall = 1'b0;
        first_cyc = -1;
        last_cyc  = -1;
        while (got < n && cyc < 300) begin
            ax_valid   = (sent < n);
            ax_addr    = 32'(32'h2000 + sent * 16);
            ax_payload = 64'(64'h100 + sent);
            res_valid  = (l1_q.size() > 0);
            if (l1_q.size() > 0) begin
                res_hit  = all_hit || !l1_q[0][4];
                res_addr = 32'hA000_0000 | l1_q[0];
            end
            mst_ready = bp ? mst_pat[cyc % 16] : 1'b1;
            err_ready = bp ? err_pat[cyc % 16] : 1'b1;
            #1;
            if (mst_stall) check_val("mst_valid_held", mst_valid, 1);
            if (err_stall) check_val("err_valid_held", err_valid, 1);
            if (mst_valid || err_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_output", 1, 0);
                end else begin
                    e = exp_q[0];
                    check_val("route_mst", mst_valid, e.hit);
                    check_val("route_err", err_valid, !e.hit);
                    if (e.hit) begin
                        check_val("mst_addr_order", mst_addr, 32'hA000_0000 | e.addr);
                        check_val("mst_payload_order", mst_payload, e.pl);
                    end else begin
                        check_val("err_addr_order", err_addr, e.addr);
                        check_val("err_payload_order", err_payload, e.pl);
                    end
                end
            end
            up_hs     = ax_valid && ax_ready;
            res_hs    = res_valid && res_ready;
            out_hs    = (mst_valid && mst_ready) || (err_valid && err_ready);
            mst_stall = mst_valid && !mst_ready;
            err_stall = err_valid && !err_ready;
            next_cycle();
            if (up_hs) begin
                l1_q.push_back(ax_addr);
                e.hit  = all_hit || (sent % 2 == 0);
                e.addr = ax_addr;
                e.pl   = ax_payload;
                exp_q.push_back(e);
                sent++;
            end
            if (res_hs && l1_q.size() > 0) void'(l1_q.pop_front());
            if (out_hs && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                got++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            cyc++;
        end
        ax_valid  = 1'b0;
        res_valid = 1'b0;
        #1;
        check_val("traffic_delivered", 64'(got), 64'(n));
        check_val("traffic_pending_zero", 64'(pending), 0);
        check_val("traffic_no_valid", 64'(mst_valid | err_valid), 0);
    endtask

    int first_c, last_c;

    initial begin
        rst_i      = 1'b1;
        ax_addr    = '0;
        ax_payload = '0;
        ax_valid   = 1'b0;
        req_ready  = 1'b1;
        res_hit    = 1'b0;
        res_addr   = '0;
        res_valid  = 1'b0;
        mst_ready  = 1'b0;
        err_ready  = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        check_val("rst_mst_valid", mst_valid, 0);
        check_val("rst_err_valid", err_valid, 0);
        check_val("rst_res_ready", res_ready, 0);
        check_val("rst_pending", 64'(pending), 0);
        check_val("rst_mst_addr", mst_addr, 0);
        check_val("rst_err_payload", err_payload, 0);
        check_val("rst_ax_ready_hi", ax_ready, 1);
        req_ready = 1'b0;
        #1;
        check_val("rst_ax_ready_lo", ax_ready, 0);
        req_ready = 1'b1;
        rst_i     = 1'b0;
        next_cycle();

        // Single hit
        ax_valid   = 1'b1;
        ax_addr    = 32'h0000_1234;
        ax_payload = 64'hAB;
        mst_ready  = 1'b1;
        #1;
        check_val("hit_req_valid", req_valid, 1);
        check_val("hit_req_addr", req_addr, 32'h0000_1234);
        check_val("hit_ax_ready", ax_ready, 1);
        next_cycle();
        ax_valid = 1'b0;
        #1;
        check_val("hit_pending_1", 64'(pending), 1);
        next_cycle();
        res_valid = 1'b1;
        res_hit   = 1'b1;
        res_addr  = 32'h8000_1234;
        #1;
        check_val("hit_res_ready", res_ready, 1);
        check_val("hit_mst_not_yet", mst_valid, 0);
        next_cycle();
        res_valid = 1'b0;
        #1;
        check_val("hit_mst_valid", mst_valid, 1);
        check_val("hit_mst_addr", mst_addr, 32'h8000_1234);
        check_val("hit_mst_payload", mst_payload, 64'hAB);
        check_val("hit_err_valid", err_valid, 0);
        check_val("hit_pending_0", 64'(pending), 0);
        next_cycle();
        check_val("hit_mst_done", mst_valid, 0);

        // Miss
        mst_ready  = 1'b0;
        err_ready  = 1'b1;
        ax_valid   = 1'b1;
        ax_addr    = 32'h0000_1234;
        ax_payload = 64'hAB;
        next_cycle();
        ax_valid = 1'b0;
        next_cycle();
        res_valid = 1'b1;
        res_hit   = 1'b0;
        res_addr  = 32'h8000_1234;
        next_cycle();
        res_valid = 1'b0;
        #1;
        check_val("miss_err_valid", err_valid, 1);
        check_val("miss_err_addr", err_addr, 32'h0000_1234);
        check_val("miss_err_payload", err_payload, 64'hAB);
        check_val("miss_mst_valid", mst_valid, 0);
        next_cycle();
        check_val("miss_err_done", err_valid, 0);
        check_val("miss_mst_never", mst_valid, 0);

        // Full stall: five beats offered, four accepted
        err_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ax_valid   = 1'b1;
            ax_addr    = 32'(32'h1000 + i);
            ax_payload = 64'(64'h500 + i);
            #1;
            check_val($sformatf("full_ax_ready_%0d", i), ax_ready, (i < 4) ? 1 : 0);
            if (i < 4) next_cycle();
        end
        check_val("full_pending_4", 64'(pending), 4);
        check_val("full_req_valid", req_valid, 0);
        res_valid = 1'b1;
        res_hit   = 1'b1;
        res_addr  = 32'h9000;
        #1;
        check_val("full_pop_res_ready", res_ready, 1);
        check_val("full_push_blocked", ax_ready, 0);
        next_cycle();
        res_valid = 1'b0;
        #1;
        check_val("full_slot_freed", ax_ready, 1);
        check_val("full_pending_3", 64'(pending), 3);
        check_val("full_mst_addr", mst_addr, 32'h9000);
        check_val("full_mst_payload", mst_payload, 64'h500);
        next_cycle();
        ax_valid = 1'b0;
        #1;
        check_val("full_refilled", 64'(pending), 4);
        check_val("full_ready_again_lo", ax_ready, 0);
        check_val("full_mst_stable", mst_payload, 64'h500);
        mst_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            res_valid = 1'b1;
            res_hit   = 1'b1;
            res_addr  = 32'(32'h9000 + k);
            next_cycle();
            check_val($sformatf("drain_mst_valid_%0d", k), mst_valid, 1);
            check_val($sformatf("drain_payload_%0d", k), mst_payload, 64'(64'h500 + k));
            check_val($sformatf("drain_addr_%0d", k), mst_addr, 32'(32'h9000 + k));
            check_val($sformatf("drain_pending_%0d", k), 64'(pending), 64'(4 - k));
        end
        res_valid = 1'b0;
        next_cycle();
        check_val("drain_done", mst_valid, 0);

        // Streaming: one beat per cycle with everything ready
        run_traffic(8, 1'b1, 1'b0, first_c, last_c);
        check_val("stream_latency", 64'(first_c), 2);
        check_val("stream_rate", 64'(last_c - first_c), 7);

        // Ordering with alternating hit/miss and backpressure, across pointer wrap
        run_traffic(8, 1'b0, 1'b1, first_c, last_c);

        // Mid-operation reset: three pending plus one held output
        mst_ready = 1'b0;
        err_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ax_valid   = 1'b1;
            ax_addr    = 32'(32'h3000 + i);
            ax_payload = 64'(64'h700 + i);
            next_cycle();
        end
        ax_valid  = 1'b0;
        res_valid = 1'b1;
        res_hit   = 1'b1;
        res_addr  = 32'h7777;
        next_cycle();
        res_valid = 1'b0;
        #1;
        check_val("mrst_pre_pending", 64'(pending), 3);
        check_val("mrst_pre_mst_valid", mst_valid, 1);
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        #1;
        check_val("mrst_mst_valid", mst_valid, 0);
        check_val("mrst_err_valid", err_valid, 0);
        check_val("mrst_pending", 64'(pending), 0);
        check_val("mrst_res_ready", res_ready, 0);
        check_val("mrst_mst_addr", mst_addr, 0);
        check_val("mrst_ax_ready_hi", ax_ready, 1);
        req_ready = 1'b0;
        #1;
        check_val("mrst_ax_ready_lo", ax_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
